// File: rtl/lab2_proc_mem_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// lab2_proc_mem_req_arbiter_if
//
// Purpose : One val/rdy message channel. The request and response streams of
//           lab2_proc_mem_req_arbiter are all instances of this interface.
//
// Parameters
//   W      message width (77 for mem_req_4B_t, 47 for mem_resp_4B_t)
//
// Signals
//   msg    [W-1:0]  message payload, driven by the producer
//   val             producer has a valid message
//   rdy             consumer accepts the message this cycle
//
// Modports
//   master  producer side (drives msg/val, observes rdy)
//   slave   consumer side (observes msg/val, drives rdy)
// ---------------------------------------------------------------------------
interface lab2_proc_mem_req_arbiter_if #(
   parameter int W = 77
);

   logic [W-1:0] msg;
   logic         val;
   logic         rdy;

   modport master (output msg, output val, input rdy);
   modport slave  (input msg, input val, output rdy);

endinterface

// File: rtl/lab2_proc_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// lab2_proc_mem_req_arbiter
//
// Purpose : Shares one 4B memory port between the imem (port 0) and dmem
//           (port 1) request streams of the pipelined processor. Requests
//           are arbitrated round-robin and passed through combinationally.
//           The ID of every accepted request is pushed into an in-order FIFO.
//           The head of that FIFO steers each memory response back to the
//           port that issued it.
//
// Parameters
//   p_max_inflight  max outstanding requests (ID FIFO depth), power of 2, >= 2
//
// Ports
//   clk          clock
//   reset        asynchronous reset, active low (asserted when 0)
//   in0_req      slave  : imem request stream   (77b mem_req_4B_t)
//   in1_req      slave  : dmem request stream   (77b mem_req_4B_t)
//   out_req      master : request to memory     (77b mem_req_4B_t)
//   out_resp     slave  : response from memory  (47b mem_resp_4B_t)
//   in0_resp     master : imem response stream  (47b mem_resp_4B_t)
//   in1_resp     master : dmem response stream  (47b mem_resp_4B_t)
//   grant_cnt0   request handshakes on port 0 (only with the macro below)
//   grant_cnt1   request handshakes on port 1 (only with the macro below)
//
// Configuration
//   LAB2_PROC_MEM_REQ_ARBITER_STATS_EN : when defined, adds the two 32-bit
//   wrapping grant counters. They are cleared by reset.
// ---------------------------------------------------------------------------
module lab2_proc_mem_req_arbiter #(
   parameter int p_max_inflight = 4
) (
   input  logic                                clk,
   input  logic                                reset,
`ifdef LAB2_PROC_MEM_REQ_ARBITER_STATS_EN
   output logic [31:0]                         grant_cnt0,
   output logic [31:0]                         grant_cnt1,
`endif
   lab2_proc_mem_req_arbiter_if.slave          in0_req,
   lab2_proc_mem_req_arbiter_if.slave          in1_req,
   lab2_proc_mem_req_arbiter_if.master         out_req,
   lab2_proc_mem_req_arbiter_if.slave          out_resp,
   lab2_proc_mem_req_arbiter_if.master         in0_resp,
   lab2_proc_mem_req_arbiter_if.master         in1_resp
);

   localparam int PtrW = $clog2(p_max_inflight);
   localparam int CntW = $clog2(p_max_inflight + 1);

   // Routing state. Each FIFO entry holds the port ID (0 = imem, 1 = dmem)
   // of a request that memory has accepted and not yet answered.
   logic                      prio_q;
   logic [p_max_inflight-1:0] id_fifo_q;
   logic [PtrW-1:0]           head_q;
   logic [PtrW-1:0]           tail_q;
   logic [CntW-1:0]           count_q;

   logic full;
   logic empty;
   logic grant0;
   logic grant1;
   logic head_id;
   logic req_fire;
   logic resp_fire;

   // ------------------------------------------------------------------------
   // Request side: grant and pass-through
   // ------------------------------------------------------------------------
   // full is checked before any pop in the same cycle. A pop therefore frees
   // a slot for the following cycle only.
   // While reset is low, no port is granted. This keeps every request-side
   // val/rdy output low without waiting for a clock edge.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      full   = (count_q == CntW'(p_max_inflight));
      empty  = (count_q == '0);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && !full) begin
         if (in0_req.val && in1_req.val) begin
            grant0 = !prio_q;
            grant1 = prio_q;
         end else begin
            grant0 = in0_req.val;
            grant1 = in1_req.val;
         end
      end
   end

   // A grant is only given to a port that is requesting. The OR of the two
   // grants is therefore the granted port's val.
   assign out_req.val = grant0 | grant1;
   assign out_req.msg = grant1 ? in1_req.msg : in0_req.msg;
   assign in0_req.rdy = grant0 & out_req.rdy;
   assign in1_req.rdy = grant1 & out_req.rdy;
   assign req_fire    = out_req.val & out_req.rdy;

   // ------------------------------------------------------------------------
   // Response side: steer by the ID at the FIFO head
   // ------------------------------------------------------------------------
   // Empty comes from the registered count. A response can therefore never
   // use an ID that is being pushed in the same cycle.
   assign head_id      = id_fifo_q[head_q];
   assign in0_resp.msg = out_resp.msg;
   assign in1_resp.msg = out_resp.msg;
   assign in0_resp.val = out_resp.val & !empty & !head_id;
   assign in1_resp.val = out_resp.val & !empty &  head_id;
   assign out_resp.rdy = !empty & (head_id ? in1_resp.rdy : in0_resp.rdy);
   assign resp_fire    = out_resp.val & out_resp.rdy;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments. All registers then
   // update together at the edge, whatever order the statements are in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q  <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (req_fire) begin
            tail_q <= tail_q + PtrW'(1);
            prio_q <= ~grant1;          // favour the port that just lost
         end
         if (resp_fire) begin
            head_q <= head_q + PtrW'(1);
         end
         case ({req_fire, resp_fire})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: ;                   // idle, or push and pop together
         endcase
      end
   end

   // NOTE: the ID storage is deliberately not reset. An entry is only read
   // while count_q says it is valid, and reset clears count_q and the pointers.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         id_fifo_q[tail_q] <= grant1;
      end
   end

`ifdef LAB2_PROC_MEM_REQ_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (in0_req.val && in0_req.rdy) grant_cnt0 <= grant_cnt0 + 32'd1;
         if (in1_req.val && in1_req.rdy) grant_cnt1 <= grant_cnt1 + 32'd1;
      end
   end
`endif

   // Memory must never answer when nothing is outstanding.
   resp_without_req_a : assert property (
      @(posedge clk) disable iff (!reset) !(out_resp.val && empty)
   ) else $error("arbiter: memory response with no request outstanding");

endmodule
